// File: rtl/rv32i_execute_sliced_alu_pkg.sv
// Shared ALU opcode and FSM state types for the sliced execute ALU.
// Optional build macro RV32I_ALU_SLT_EN adds SLT/SLTU to the sliced opcode set.
package rv32i_execute_sliced_alu_pkg;

  localparam int unsigned ALU_SEL_W = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_LUI  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Opcodes that walk the slice datapath; everything else completes at accept.
  function automatic logic uses_slices(input alu_sel_e sel);
    logic r;
    r = 1'b0;
    case (sel)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: r = 1'b1;
`ifdef RV32I_ALU_SLT_EN
      ALU_SLT, ALU_SLTU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_subtract(input alu_sel_e sel);
    return (sel == ALU_SUB) || (sel == ALU_SLT) || (sel == ALU_SLTU);
  endfunction

endpackage

// File: rtl/rv32i_execute_sliced_alu_slice.sv
// One combinational datapath slice: add with carry, and, or, xor.
module rv32i_execute_sliced_alu_slice
  import rv32i_execute_sliced_alu_pkg::*;
#(
  parameter int unsigned SLICE_W = 16
) (
  input  alu_sel_e             op,
  input  logic [SLICE_W-1:0]   a,
  input  logic [SLICE_W-1:0]   b,
  input  logic                 cin,
  output logic [SLICE_W-1:0]   y_c,
  output logic                 cout_c
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum    = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
    y_c    = '0;
    cout_c = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: begin
        y_c    = sum[SLICE_W-1:0];
        cout_c = sum[SLICE_W];
      end
      ALU_AND: y_c = a & b;
      ALU_OR:  y_c = a | b;
      ALU_XOR: y_c = a ^ b;
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_execute_sliced_alu.sv
// Multi-cycle RV32I execute ALU processing one SLICE_W chunk per cycle, LSB first.
// Optional macro RV32I_ALU_SLT_EN enables SLT/SLTU as subtract passes.
module rv32i_execute_sliced_alu
  import rv32i_execute_sliced_alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ALU_SEL_W-1:0] i_alu_sel,
  input  logic [XLEN-1:0]      i_alu_operand_one,
  input  logic [XLEN-1:0]      i_alu_operand_two,
  output logic                 o_alu_data_valid,
  input  logic                 i_result_ready,
  output logic [XLEN-1:0]      o_alu_result,
  output logic                 o_alu_carry_out
);

  localparam int unsigned NUM_SLICES = XLEN / SLICE_W;
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if ((XLEN % SLICE_W) != 0) begin : g_bad_slice_w
    $error("XLEN must be a multiple of SLICE_W");
  end

  alu_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic [XLEN-1:0]     op_a_q;
  logic [XLEN-1:0]     op_b_q;
  alu_sel_e            sel_q;

  alu_sel_e            in_sel;
  logic                sub_op;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic                slice_cin;
  logic [SLICE_W-1:0]  slice_y;
  logic                slice_cout;

  // LUI places the 20-bit immediate in the top bits, zero below.
  function automatic logic [XLEN-1:0] lui_imm(input logic [XLEN-1:0] b);
    return XLEN'(b[19:0]) << (XLEN - 20);
  endfunction

  always_comb begin
    in_sel    = alu_sel_e'(i_alu_sel);
    sub_op    = is_subtract(sel_q);
    slice_a   = op_a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b   = op_b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_op}};
    slice_cin = (idx_q == '0) ? sub_op : carry_q;
  end

  rv32i_execute_sliced_alu_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .op     (sel_q),
    .a      (slice_a),
    .b      (slice_b),
    .cin    (slice_cin),
    .y_c    (slice_y),
    .cout_c (slice_cout)
  );

`ifdef RV32I_ALU_SLT_EN
  logic slt_lt;

  // Signed compare falls back to the difference sign only when the operand signs agree.
  always_comb begin
    slt_lt = ~slice_cout;
    if (sel_q == ALU_SLT) begin
      slt_lt = (op_a_q[XLEN-1] ^ op_b_q[XLEN-1]) ? op_a_q[XLEN-1] : slice_y[SLICE_W-1];
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      carry_q          <= 1'b0;
      op_a_q           <= '0;
      op_b_q           <= '0;
      sel_q            <= ALU_ADD;
      o_ready          <= 1'b1;
      o_alu_data_valid <= 1'b0;
      o_alu_result     <= '0;
      o_alu_carry_out  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            op_a_q          <= i_alu_operand_one;
            op_b_q          <= i_alu_operand_two;
            sel_q           <= in_sel;
            idx_q           <= '0;
            carry_q         <= 1'b0;
            o_ready         <= 1'b0;
            o_alu_carry_out <= 1'b0;
            if (uses_slices(in_sel)) begin
              state_q      <= ST_EXEC;
              o_alu_result <= '0;
            end else begin
              state_q          <= ST_DONE;
              o_alu_data_valid <= 1'b1;
              o_alu_result     <= (in_sel == ALU_LUI) ? lui_imm(i_alu_operand_two) : '0;
            end
          end
        end
        ST_EXEC: begin
          o_alu_result[idx_q*SLICE_W +: SLICE_W] <= slice_y;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            state_q          <= ST_DONE;
            o_alu_data_valid <= 1'b1;
            o_alu_carry_out  <= ((sel_q == ALU_ADD) || (sel_q == ALU_SUB)) ? slice_cout : 1'b0;
`ifdef RV32I_ALU_SLT_EN
            if ((sel_q == ALU_SLT) || (sel_q == ALU_SLTU)) begin
              o_alu_result <= XLEN'(slt_lt);
            end
`endif
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (i_result_ready) begin
            state_q          <= ST_IDLE;
            o_alu_data_valid <= 1'b0;
            o_ready          <= 1'b1;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          o_ready          <= 1'b1;
          o_alu_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
